// File: rtl/key_match_lookup_pkg.sv
// Shared constants and types for the key match lookup stage.
package key_match_lookup_pkg;

    localparam int PHV_LEN    = 48*8 + 32*8 + 16*8 + 5*20 + 256;  // 1124
    localparam int KEY_LEN    = 48*2 + 32*2 + 16*2 + 5;           // 197
    localparam int ENTRIES    = 16;
    localparam int AXIL_WIDTH = 32;
    localparam int CFG_ADDR_W = 8;

    // vlan_id lives at phv[140:129]; the tenant tag is vlan_id[7:4]
    localparam int VLAN_LSB   = 129;
    localparam int VLAN_MSB   = 140;
    localparam int TENANT_LSB = VLAN_LSB + 4;
    localparam int TENANT_W   = 4;

    // config word indices within one entry's 16-word window
    localparam int VAL_W0         = 0;
    localparam int MSK_W0         = 7;
    localparam int CTRL_W         = 14;
    localparam int KEY_WORDS      = 7;
    localparam int CTRL_VALID_BIT = 4;

    typedef struct packed {
        logic                valid;
        logic [TENANT_W-1:0] tenant;
    } entry_ctrl_t;

    function automatic logic [TENANT_W-1:0] phv_tenant(input logic [PHV_LEN-1:0] phv);
        return phv[TENANT_LSB +: TENANT_W];
    endfunction

endpackage

// File: rtl/key_match_lookup_if.sv
// Config write bus: one 32-bit word per cycle, addressed by entry/word.
interface key_match_lookup_if
    import key_match_lookup_pkg::*;
();
    logic [AXIL_WIDTH-1:0] cfg_data;
    logic                  cfg_valid;
    logic [CFG_ADDR_W-1:0] cfg_addr;

    modport master (output cfg_data, cfg_valid, cfg_addr);
    modport slave  (input  cfg_data, cfg_valid, cfg_addr);
endinterface

// File: rtl/key_match_lookup_entry.sv
// One ternary table entry: holds value/mask/ctrl, loads them atomically on
// commit, and flags a match against the presented key and tenant.
module key_match_lookup_entry
    import key_match_lookup_pkg::*;
#(
    parameter int KEY_W = key_match_lookup_pkg::KEY_LEN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [KEY_W-1:0]    value_in,
    input  logic [KEY_W-1:0]    mask_in,
    input  entry_ctrl_t         ctrl_in,
    input  logic [KEY_W-1:0]    key,
    input  logic [TENANT_W-1:0] tenant,
    output logic                match
);
    logic [KEY_W-1:0] value_q;
    logic [KEY_W-1:0] mask_q;
    entry_ctrl_t      ctrl_q;

    // commit copies the whole entry in one edge so lookups never see a mix
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q <= '0;
            mask_q  <= '0;
            ctrl_q  <= '0;
        end else if (load) begin
            value_q <= value_in;
            mask_q  <= mask_in;
            ctrl_q  <= ctrl_in;
        end
    end

    // mask bit 1 = care; an all-zero mask is a per-tenant wildcard
    assign match = ctrl_q.valid && (ctrl_q.tenant == tenant) &&
                   (((key ^ value_q) & mask_q) == '0);

endmodule

// File: rtl/key_match_lookup.sv
// Ternary match stage: 16-entry tenant-tagged value/mask table, two-stage
// pipeline (match vector, then priority encode), shadow-buffered config.
module key_match_lookup
    import key_match_lookup_pkg::*;
#(
    parameter int STAGE      = 0,
    parameter int PHV_LEN    = key_match_lookup_pkg::PHV_LEN,
    parameter int KEY_LEN    = key_match_lookup_pkg::KEY_LEN,
    parameter int ENTRIES    = key_match_lookup_pkg::ENTRIES,
    parameter int AXIL_WIDTH = key_match_lookup_pkg::AXIL_WIDTH,
    parameter int CFG_ADDR_W = key_match_lookup_pkg::CFG_ADDR_W,
    localparam int IDX_W     = $clog2(ENTRIES)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PHV_LEN-1:0]   phv_in,
    input  logic                 phv_valid_in,
    input  logic [KEY_LEN-1:0]   key_in,
    input  logic                 key_valid_in,
    key_match_lookup_if.slave    cfg,
    output logic [PHV_LEN-1:0]   phv_out,
    output logic                 phv_valid_out,
    output logic [IDX_W-1:0]     match_idx,
    output logic                 hit,
    output logic                 match_valid
);
    localparam int STAGES = 2;

    logic [3:0]         word_idx;
    logic [IDX_W-1:0]   entry_sel;
    logic               commit;
    entry_ctrl_t        ctrl_word;
    logic [KEY_LEN-1:0] shadow_val;
    logic [KEY_LEN-1:0] shadow_msk;
    logic [ENTRIES-1:0] match_vec;
    logic [ENTRIES-1:0] match_s1;
    logic [PHV_LEN-1:0] phv_s1;
    logic [STAGES:1]    vld_pipe;
    logic [STAGES:1]    phv_vld_pipe;
    logic [IDX_W-1:0]   enc_idx;

    assign word_idx  = cfg.cfg_addr[3:0];
    assign entry_sel = cfg.cfg_addr[4 +: IDX_W];
    assign commit    = cfg.cfg_valid && (word_idx == 4'(CTRL_W));
    assign ctrl_word = '{valid:  cfg.cfg_data[CTRL_VALID_BIT],
                         tenant: cfg.cfg_data[TENANT_W-1:0]};

    // shadow value/mask collect words 0..13; bits beyond KEY_LEN in the top word drop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_msk <= '0;
        end else if (cfg.cfg_valid) begin
            for (int b = 0; b < KEY_LEN; b++) begin
                if (int'(word_idx) == VAL_W0 + b / AXIL_WIDTH)
                    shadow_val[b] <= cfg.cfg_data[b % AXIL_WIDTH];
                if (int'(word_idx) == MSK_W0 + b / AXIL_WIDTH)
                    shadow_msk[b] <= cfg.cfg_data[b % AXIL_WIDTH];
            end
        end
    end

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        key_match_lookup_entry #(.KEY_W(KEY_LEN)) u_entry (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (commit && (entry_sel == IDX_W'(e))),
            .value_in (shadow_val),
            .mask_in  (shadow_msk),
            .ctrl_in  (ctrl_word),
            .key      (key_in),
            .tenant   (phv_tenant(phv_in)),
            .match    (match_vec[e])
        );
    end

    // S1: capture the match vector against this cycle's table; invalid keys match nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_s1       <= '0;
            match_s1     <= '0;
            vld_pipe     <= '0;
            phv_vld_pipe <= '0;
        end else begin
            phv_s1       <= phv_in;
            match_s1     <= key_valid_in ? match_vec : '0;
            vld_pipe     <= {vld_pipe[STAGES-1:1], key_valid_in};
            phv_vld_pipe <= {phv_vld_pipe[STAGES-1:1], phv_valid_in};
        end
    end

    // lowest index wins; scanning downward lets the lowest hit overwrite the rest
    always_comb begin
        enc_idx = '0;
        for (int e = ENTRIES - 1; e >= 0; e--)
            if (match_s1[e]) enc_idx = IDX_W'(e);
    end

    // S2: registered lookup result and PHV
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phv_out   <= '0;
            hit       <= 1'b0;
            match_idx <= '0;
        end else begin
            phv_out   <= phv_s1;
            hit       <= |match_s1;
            match_idx <= enc_idx;
        end
    end

    assign match_valid   = vld_pipe[STAGES];
    assign phv_valid_out = phv_vld_pipe[STAGES];

endmodule

// File: tb/tb_key_match_lookup.sv
// Directed bench for key_match_lookup with a reference table model and
// result/PHV scoreboards popped as the DUT produces output.
module tb_key_match_lookup;
    localparam int PL = 1124;
    localparam int KL = 197;

    typedef struct packed { logic hit; logic [3:0] idx; } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PL-1:0] phv_in = '0;
    logic          phv_valid_in = 1'b0;
    logic [KL-1:0] key_in = '0;
    logic          key_valid_in = 1'b0;
    logic [PL-1:0] phv_out;
    logic          phv_valid_out;
    logic [3:0]    match_idx;
    logic          hit;
    logic          match_valid;

    key_match_lookup_if cfg_if ();

    key_match_lookup dut (
        .clk(clk), .rst_n(rst_n), .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .key_in(key_in), .key_valid_in(key_valid_in), .cfg(cfg_if),
        .phv_out(phv_out), .phv_valid_out(phv_valid_out), .match_idx(match_idx),
        .hit(hit), .match_valid(match_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t          exp_q[$];
    logic [PL-1:0] phv_q[$];

    // reference table
    logic [KL-1:0] m_shv, m_shm;
    logic [KL-1:0] m_val[16];
    logic [KL-1:0] m_msk[16];
    logic [3:0]    m_ten[16];
    logic          m_vld[16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_shv = '0;
        m_shm = '0;
        for (int e = 0; e < 16; e++) begin
            m_val[e] = '0; m_msk[e] = '0; m_ten[e] = '0; m_vld[e] = 1'b0;
        end
    endtask

    task automatic model_cfg(input logic [7:0] a, input logic [31:0] d);
        logic [223:0] tmp;
        int w, e;
        w = int'(a[3:0]);
        e = int'(a[7:4]);
        if (w < 7) begin
            tmp = 224'(m_shv); tmp[w*32 +: 32] = d; m_shv = tmp[KL-1:0];
        end else if (w < 14) begin
            tmp = 224'(m_shm); tmp[(w-7)*32 +: 32] = d; m_shm = tmp[KL-1:0];
        end else if (w == 14) begin
            m_val[e] = m_shv; m_msk[e] = m_shm; m_ten[e] = d[3:0]; m_vld[e] = d[4];
        end
    endtask

    function automatic exp_t model_lookup(input logic [KL-1:0] k, input logic [PL-1:0] p);
        exp_t r;
        logic [3:0] ten;
        ten = p[136:133];
        r = '0;
        for (int e = 15; e >= 0; e--)
            if (m_vld[e] && m_ten[e] == ten && ((k ^ m_val[e]) & m_msk[e]) == '0) begin
                r.hit = 1'b1; r.idx = 4'(e);
            end
        return r;
    endfunction

    function automatic logic [KL-1:0] rand_key();
        logic [223:0] t;
        for (int i = 0; i < 7; i++) t[i*32 +: 32] = $urandom;
        return t[KL-1:0];
    endfunction

    function automatic logic [PL-1:0] make_phv(input logic [3:0] ten);
        logic [1151:0] t;
        logic [PL-1:0] p;
        for (int i = 0; i < 36; i++) t[i*32 +: 32] = $urandom;
        p = t[PL-1:0];
        p[136:133] = ten;
        return p;
    endfunction

    // drive one cycle of inputs, record expectations, then advance past the edge
    task automatic step(input logic kv, input logic [KL-1:0] k, input logic pv, input logic [PL-1:0] p,
                        input logic cv, input logic [7:0] ca, input logic [31:0] cd);
        key_valid_in = kv; key_in = k; phv_valid_in = pv; phv_in = p;
        cfg_if.cfg_valid = cv; cfg_if.cfg_addr = ca; cfg_if.cfg_data = cd;
        if (kv) exp_q.push_back(model_lookup(k, p));
        if (pv) phv_q.push_back(p);
        if (cv) model_cfg(ca, cd);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    endtask

    task automatic lookup(input logic [KL-1:0] k, input logic [3:0] ten);
        step(1'b1, k, 1'b1, make_phv(ten), 1'b0, '0, '0);
    endtask

    // write words 0..13 then commit; optionally stream key sk (tenant 2) every cycle
    task automatic prog_entry(input logic [3:0] e, input logic [KL-1:0] v, input logic [KL-1:0] m,
                              input logic [3:0] ten, input logic vld, input logic kv, input logic [KL-1:0] sk);
        logic [223:0] vp, mp;
        vp = 224'(v);
        mp = 224'(m);
        for (int w = 0; w < 7; w++)
            step(kv, sk, kv, make_phv(4'd2), 1'b1, {e, 4'(w)}, vp[w*32 +: 32]);
        for (int w = 0; w < 7; w++)
            step(kv, sk, kv, make_phv(4'd2), 1'b1, {e, 4'(w + 7)}, mp[w*32 +: 32]);
        step(kv, sk, kv, make_phv(4'd2), 1'b1, {e, 4'd14}, {27'b0, vld, ten});
    endtask

    // output monitor: pop scoreboards on valid, require quiet outputs otherwise
    always @(negedge clk) begin
        exp_t e;
        logic [PL-1:0] pe;
        if (match_valid) begin
            check("match_unexpected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("match", 64'({hit, match_idx}), 64'({e.hit, e.idx}));
            end
        end else begin
            check("idle_result", 64'({hit, match_idx}), 64'd0);
        end
        if (phv_valid_out) begin
            check("phv_unexpected", 64'(phv_q.size() != 0), 64'd1);
            if (phv_q.size() != 0) begin
                pe = phv_q.pop_front();
                checks++;
                assert (phv_out === pe) else begin
                    errors++;
                    $error("FAIL phv_out observed[63:0]=%h expected[63:0]=%h", phv_out[63:0], pe[63:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    logic [KL-1:0] k3, k5;
    logic [KL-1:0] ones;

    initial begin
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_addr = '0; cfg_if.cfg_data = '0;
        ones = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_match_valid", 64'(match_valid), 64'd0);
        check("rst_hit_idx", 64'({hit, match_idx}), 64'd0);
        check("rst_phv_valid", 64'(phv_valid_out), 64'd0);
        check("rst_phv_zero", 64'(phv_out == '0), 64'd1);
        rst_n = 1'b1;
        idle(2);

        // empty table: miss
        lookup(rand_key(), 4'd2);
        idle(3);

        // exact entry 3, tenant 2
        k3 = rand_key();
        prog_entry(4'd3, k3, ones, 4'd2, 1'b1, 1'b0, '0);
        lookup(k3, 4'd2);
        lookup(k3, 4'd5);
        lookup(k3 ^ {{(KL-1){1'b0}}, 1'b1}, 4'd2);
        idle(3);

        // wildcard entry 1 outranks entry 3, then disable it
        prog_entry(4'd1, rand_key(), '0, 4'd2, 1'b1, 1'b0, '0);
        lookup(k3, 4'd2);
        lookup(rand_key(), 4'd2);
        lookup(k3, 4'd3);
        step(1'b0, '0, 1'b0, '0, 1'b1, {4'd1, 4'd14}, {27'b0, 1'b0, 4'd2});
        lookup(k3, 4'd2);
        idle(3);

        // commit entry 5 while K5 streams: commit-cycle lookup misses, next one hits
        k5 = rand_key();
        prog_entry(4'd5, k5, ones, 4'd2, 1'b1, 1'b1, k5);
        lookup(k5, 4'd2);
        lookup(k3, 4'd2);
        idle(3);

        // back-to-back alternating hit/miss
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) lookup(k3, 4'd2);
            else            lookup(rand_key(), 4'd7);
        end
        idle(4);

        // reset with two lookups in flight
        lookup(k3, 4'd2);
        lookup(k5, 4'd2);
        rst_n = 1'b0;
        key_valid_in = 1'b0; phv_valid_in = 1'b0;
        #1;
        check("midrst_match_valid", 64'(match_valid), 64'd0);
        check("midrst_hit_idx", 64'({hit, match_idx}), 64'd0);
        check("midrst_phv_valid", 64'(phv_valid_out), 64'd0);
        check("midrst_phv_zero", 64'(phv_out == '0), 64'd1);
        exp_q.delete();
        phv_q.delete();
        model_reset();
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(3);
        lookup(k3, 4'd2);
        lookup(k5, 4'd2);
        idle(4);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        check("phv_q_drained", 64'(phv_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
